// File: rtl/ibex_fp_rf_pkg.sv
// Shared types and constants for the FP register file with scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ibex_fp_rf_pkg;

    // Number of read ports: rs1, rs2 and rs3 (rs3 feeds FMA).
    localparam int unsigned NumRdPorts = 3;

    // Write-port arbiter state: which writeback source wins a collision.
    typedef enum logic {
        LD_PRI  = 1'b0,
        FPU_PRI = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ibex_fp_rf_wr_arb.sv
// Two-source write-port arbiter (load vs FPU writeback) for the FP register file.
// Latency: combinational grant; priority state updates on the next clk_i edge.
// Backpressure: the losing source sees ready low for at most one cycle, then wins.
module ibex_fp_rf_wr_arb
    import ibex_fp_rf_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic ld_valid_i,
    input  logic fpu_valid_i,
    output logic ld_ready_o,
    output logic fpu_ready_o
);

    arb_state_e state_q, state_d;
    logic       fpu_acc;

    // State register: loads have priority out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LD_PRI;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants: the priority source is always ready, the other only if the priority one is idle.
    always_comb begin
        ld_ready_o  = 1'b1;
        fpu_ready_o = 1'b1;
        case (state_q)
            LD_PRI:  fpu_ready_o = !ld_valid_i;
            FPU_PRI: ld_ready_o  = !fpu_valid_i;
            default: begin
                ld_ready_o  = 1'b1;
                fpu_ready_o = 1'b1;
            end
        endcase
    end

    assign fpu_acc = fpu_valid_i && fpu_ready_o;

    // Next state: a stalled FPU write gets priority next cycle, which it gives back straight away.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_PRI: begin
                if (fpu_valid_i && !fpu_acc) begin
                    state_d = FPU_PRI;
                end
            end
            FPU_PRI: begin
                if (fpu_acc || !fpu_valid_i) begin
                    state_d = LD_PRI;
                end
            end
            default: state_d = LD_PRI;
        endcase
    end

endmodule

// File: rtl/ibex_fp_register_file_sb.sv
// FP register file with one arbitrated write port, three read ports and a busy scoreboard.
// Latency: reads combinational (optional same-cycle write forwarding), writes land in 1 cycle.
// Backpressure: issue stalls on a busy destination (WAW); writebacks stall at most 1 cycle.
module ibex_fp_register_file_sb
    import ibex_fp_rf_pkg::*;
#(
    parameter int unsigned           DataWidth   = 32,
    parameter int unsigned           NumWords    = 32,
    parameter bit                    ZeroReg0    = 1'b0,
    parameter bit                    BypassEn    = 1'b1,
    parameter bit                    WrenCheck   = 1'b0,
    parameter logic [DataWidth-1:0]  WordZeroVal = '0,
    localparam int unsigned          AddrWidth   = $clog2(NumWords)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumRdPorts-1:0][AddrWidth-1:0]  raddr_i,
    output logic [NumRdPorts-1:0][DataWidth-1:0]  rdata_o,
    output logic [NumRdPorts-1:0]                 rbusy_o,
    input  logic                                  iss_valid_i,
    input  logic [AddrWidth-1:0]                  iss_waddr_i,
    output logic                                  iss_ready_o,
    input  logic                                  fpu_valid_i,
    input  logic [AddrWidth-1:0]                  fpu_waddr_i,
    input  logic [DataWidth-1:0]                  fpu_wdata_i,
    output logic                                  fpu_ready_o,
    input  logic                                  ld_valid_i,
    input  logic [AddrWidth-1:0]                  ld_waddr_i,
    input  logic [DataWidth-1:0]                  ld_wdata_i,
    output logic                                  ld_ready_o,
    output logic [NumWords-1:0]                   busy_o,
    output logic                                  err_o
);

    // Storage is never reset; it only carries its power-up value.
    logic [DataWidth-1:0] mem_q [NumWords] = '{default: WordZeroVal};
    logic [NumWords-1:0]  busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 ld_acc, fpu_acc;
    logic                 wr_en;
    logic [AddrWidth-1:0] wr_addr;
    logic [DataWidth-1:0] wr_data;
    logic                 iss_set;

    // Address maps onto a real, writable word (not out of range, not the hardwired zero).
    function automatic logic addr_live(input logic [AddrWidth-1:0] a);
        return (32'(a) < NumWords) && !(ZeroReg0 && (a == '0));
    endfunction

    // Scoreboard lookup that treats out-of-range addresses as never busy.
    function automatic logic busy_at(input logic [NumWords-1:0] b, input logic [AddrWidth-1:0] a);
        return (32'(a) < NumWords) ? b[a] : 1'b0;
    endfunction

    ibex_fp_rf_wr_arb u_wr_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ld_valid_i  (ld_valid_i),
        .fpu_valid_i (fpu_valid_i),
        .ld_ready_o  (ld_ready_o),
        .fpu_ready_o (fpu_ready_o)
    );

    // Grants are mutually exclusive, so one mux feeds the single physical write port.
    assign ld_acc  = ld_valid_i && ld_ready_o;
    assign fpu_acc = fpu_valid_i && fpu_ready_o;
    assign wr_addr = ld_acc ? ld_waddr_i : fpu_waddr_i;
    assign wr_data = ld_acc ? ld_wdata_i : fpu_wdata_i;
    // A write that coincides with reset is dropped along with ignored/out-of-range ones.
    assign wr_en   = (ld_acc || fpu_acc) && addr_live(wr_addr) && !rst_i;

    assign iss_ready_o = !busy_at(busy_q, iss_waddr_i);
    assign iss_set     = iss_valid_i && iss_ready_o && addr_live(iss_waddr_i);

    // Storage write port: plain clocked write, no reset, keeps LUTRAM inference.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Scoreboard next state: writeback clears, issue sets, set wins on the same word.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < int'(NumWords); w++) begin
            if (wr_en && (wr_addr == AddrWidth'(w))) begin
                busy_d[w] = 1'b0;
            end
            if (iss_set && (iss_waddr_i == AddrWidth'(w))) begin
                busy_d[w] = 1'b1;
            end
        end
    end

    // Sticky error: a writeback arrived for a word that had no outstanding issue.
    always_comb begin
        err_d = err_q;
        if (WrenCheck && wr_en && !busy_at(busy_q, wr_addr)) begin
            err_d = 1'b1;
        end
    end

    // Scoreboard and error flag reset immediately; storage does not.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    // Read ports: zero word / out of range, then same-cycle forwarding, then storage.
    always_comb begin
        for (int p = 0; p < int'(NumRdPorts); p++) begin
            rdata_o[p] = '0;
            rbusy_o[p] = 1'b0;
            if (addr_live(raddr_i[p])) begin
                if (BypassEn && wr_en && (wr_addr == raddr_i[p])) begin
                    rdata_o[p] = wr_data;
                end else begin
                    rdata_o[p] = mem_q[raddr_i[p]];
                    rbusy_o[p] = busy_q[raddr_i[p]];
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_ibex_fp_register_file_sb.sv
module tb_ibex_fp_register_file_sb;

    logic            clk;
    logic            rst;
    logic [2:0][4:0] raddr;
    logic [2:0][31:0] rdata;
    logic [2:0]      rbusy;
    logic            iss_valid;
    logic [4:0]      iss_waddr;
    logic            iss_ready;
    logic            fpu_valid;
    logic [4:0]      fpu_waddr;
    logic [31:0]     fpu_wdata;
    logic            fpu_ready;
    logic            ld_valid;
    logic [4:0]      ld_waddr;
    logic [31:0]     ld_wdata;
    logic            ld_ready;
    logic [31:0]     busy;
    logic            err;

    int n_chk = 0;
    int n_err = 0;

    ibex_fp_register_file_sb #(
        .DataWidth   (32),
        .NumWords    (32),
        .ZeroReg0    (1'b1),
        .BypassEn    (1'b1),
        .WrenCheck   (1'b1),
        .WordZeroVal (32'h0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .raddr_i     (raddr),
        .rdata_o     (rdata),
        .rbusy_o     (rbusy),
        .iss_valid_i (iss_valid),
        .iss_waddr_i (iss_waddr),
        .iss_ready_o (iss_ready),
        .fpu_valid_i (fpu_valid),
        .fpu_waddr_i (fpu_waddr),
        .fpu_wdata_i (fpu_wdata),
        .fpu_ready_o (fpu_ready),
        .ld_valid_i  (ld_valid),
        .ld_waddr_i  (ld_waddr),
        .ld_wdata_i  (ld_wdata),
        .ld_ready_o  (ld_ready),
        .busy_o      (busy),
        .err_o       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural reference model ----------------
    // Register file = array of words, scoreboard = one flag per register,
    // arbitration = "an FPU write that lost last cycle wins this cycle".
    logic [31:0] m_mem  [32];
    bit          m_busy [32];
    bit          m_err;
    bit          m_stall;

    bit          nx_we;
    logic [4:0]  nx_wa;
    logic [31:0] nx_wd;
    bit          nx_set;
    logic [4:0]  nx_sa;
    bit          nx_err;
    bit          nx_stall;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_err   = 1'b0;
        m_stall = 1'b0;
    endtask

    task automatic model_eval_check();
        bit          e_ldr, e_fpr, lacc, facc, weff, e_issr, e_rb;
        logic [4:0]  wa, a;
        logic [31:0] wd, e_rd, e_busy;
        e_ldr  = m_stall ? !fpu_valid : 1'b1;
        e_fpr  = m_stall ? 1'b1 : !ld_valid;
        lacc   = ld_valid && e_ldr;
        facc   = fpu_valid && e_fpr;
        wa     = lacc ? ld_waddr : fpu_waddr;
        wd     = lacc ? ld_wdata : fpu_wdata;
        weff   = (lacc || facc) && (wa != 5'd0);
        e_issr = !m_busy[iss_waddr];
        e_busy = '0;
        for (int i = 0; i < 32; i++) e_busy[i] = m_busy[i];
        for (int p = 0; p < 3; p++) begin
            a = raddr[p];
            if (a == 5'd0) begin
                e_rd = '0; e_rb = 1'b0;
            end else if (weff && wa == a) begin
                e_rd = wd; e_rb = 1'b0;
            end else begin
                e_rd = m_mem[a]; e_rb = m_busy[a];
            end
            chk($sformatf("model rdata[%0d]", p), rdata[p], e_rd);
            chk($sformatf("model rbusy[%0d]", p), 32'(rbusy[p]), 32'(e_rb));
        end
        chk("model ld_ready",  32'(ld_ready),  32'(e_ldr));
        chk("model fpu_ready", 32'(fpu_ready), 32'(e_fpr));
        chk("model iss_ready", 32'(iss_ready), 32'(e_issr));
        chk("model busy",      busy,           e_busy);
        chk("model err",       32'(err),       32'(m_err));
        nx_we    = weff;
        nx_wa    = wa;
        nx_wd    = wd;
        nx_set   = iss_valid && e_issr && (iss_waddr != 5'd0);
        nx_sa    = iss_waddr;
        nx_err   = m_err || (weff && !m_busy[wa]);
        nx_stall = fpu_valid && !facc;
    endtask

    task automatic model_commit();
        if (nx_we) begin
            m_mem[nx_wa]  = nx_wd;
            m_busy[nx_wa] = 1'b0;
        end
        if (nx_set) m_busy[nx_sa] = 1'b1;
        m_err   = nx_err;
        m_stall = nx_stall;
    endtask

    // Inputs change at posedge+1, outputs are sampled at posedge+2.
    task automatic cycle_mid();
        #1;
        model_eval_check();
    endtask

    task automatic cycle_end();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_waddr = '0;
        fpu_valid = 1'b0; fpu_waddr = '0; fpu_wdata = '0;
        ld_valid  = 1'b0; ld_waddr  = '0; ld_wdata  = '0;
        raddr     = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          iss_v;
        logic [4:0]  iss_a;
        bit          fpu_v;
        logic [4:0]  fpu_a;
        logic [31:0] fpu_d;
        bit          ld_v;
        logic [4:0]  ld_a;
        logic [31:0] ld_d;
        logic [4:0]  ra;
        bit          e_ldr;
        bit          e_fpr;
        bit          e_issr;
        logic [31:0] e_rd;
        bit          e_rb;
        logic [31:0] e_busy;
        bit          e_err;
    } vec_t;

    function automatic vec_t mk(input int iv, input int ia, input int fv, input int fa,
                                input logic [31:0] fd, input int lv, input int la,
                                input logic [31:0] ld, input int ra, input int eldr,
                                input int efpr, input int eissr, input logic [31:0] erd,
                                input int erb, input logic [31:0] ebusy, input int eerr);
        vec_t v;
        v.iss_v = 1'(iv);   v.iss_a = 5'(ia);
        v.fpu_v = 1'(fv);   v.fpu_a = 5'(fa);  v.fpu_d = fd;
        v.ld_v  = 1'(lv);   v.ld_a  = 5'(la);  v.ld_d  = ld;
        v.ra    = 5'(ra);
        v.e_ldr = 1'(eldr); v.e_fpr = 1'(efpr); v.e_issr = 1'(eissr);
        v.e_rd  = erd;      v.e_rb  = 1'(erb);  v.e_busy = ebusy; v.e_err = 1'(eerr);
        return v;
    endfunction

    vec_t tbl [21];

    initial begin
        //            iss    fpu                  ld                   ra  ldr fpr iss rdata        rb busy         err
        tbl[0]  = mk(1, 5, 0, 0, 32'h0,        0, 0, 32'h0,        5,  1, 1, 1, 32'h0,        0, 32'h0,       0);
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        5,  1, 1, 1, 32'h0,        1, 32'h20,      0);
        tbl[2]  = mk(0, 0, 1, 5, 32'h3F800000, 0, 0, 32'h0,        5,  1, 1, 1, 32'h3F800000, 0, 32'h20,      0);
        tbl[3]  = mk(1, 0, 0, 0, 32'h0,        1, 0, 32'hFFFFFFFF, 0,  1, 0, 1, 32'h0,        0, 32'h0,       0);
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        5,  1, 1, 1, 32'h3F800000, 0, 32'h0,       0);
        tbl[5]  = mk(1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        1,  1, 1, 1, 32'h0,        0, 32'h0,       0);
        tbl[6]  = mk(1, 2, 0, 0, 32'h0,        0, 0, 32'h0,        1,  1, 1, 1, 32'h0,        1, 32'h2,       0);
        tbl[7]  = mk(0, 0, 1, 2, 32'h22222222, 1, 1, 32'h11111111, 1,  1, 0, 1, 32'h11111111, 0, 32'h6,       0);
        tbl[8]  = mk(0, 0, 1, 2, 32'h22222222, 1, 1, 32'h33333333, 2,  0, 1, 1, 32'h22222222, 0, 32'h4,       0);
        tbl[9]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1,  1, 1, 1, 32'h11111111, 0, 32'h0,       0);
        tbl[10] = mk(1, 7, 0, 0, 32'h0,        0, 0, 32'h0,        7,  1, 1, 1, 32'h0,        0, 32'h0,       0);
        tbl[11] = mk(0, 0, 0, 0, 32'h0,        1, 7, 32'hDEADBEEF, 7,  1, 0, 1, 32'hDEADBEEF, 0, 32'h80,      0);
        tbl[12] = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        7,  1, 1, 1, 32'hDEADBEEF, 0, 32'h0,       0);
        tbl[13] = mk(1, 3, 0, 0, 32'h0,        0, 0, 32'h0,        3,  1, 1, 1, 32'h0,        0, 32'h0,       0);
        tbl[14] = mk(1, 3, 0, 0, 32'h0,        0, 0, 32'h0,        3,  1, 1, 0, 32'h0,        1, 32'h8,       0);
        tbl[15] = mk(1, 3, 1, 3, 32'hCAFEF00D, 0, 0, 32'h0,        3,  1, 1, 0, 32'hCAFEF00D, 0, 32'h8,       0);
        tbl[16] = mk(1, 3, 0, 0, 32'h0,        0, 0, 32'h0,        3,  1, 1, 1, 32'hCAFEF00D, 0, 32'h0,       0);
        tbl[17] = mk(1, 4, 0, 0, 32'h0,        1, 3, 32'h0BADF00D, 3,  1, 0, 1, 32'h0BADF00D, 0, 32'h8,       0);
        tbl[18] = mk(0, 0, 1, 4, 32'h44444444, 0, 0, 32'h0,        4,  1, 1, 1, 32'h44444444, 0, 32'h10,      0);
        tbl[19] = mk(1, 4, 0, 0, 32'h0,        0, 0, 32'h0,        4,  1, 1, 1, 32'h44444444, 0, 32'h0,       0);
        tbl[20] = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        4,  1, 1, 1, 32'h44444444, 1, 32'h10,      0);
    end

    // ---------------- test sequence ----------------
    initial begin
        foreach (m_mem[i]) m_mem[i] = 32'h0;
        model_reset();
        rst = 1'b1;
        idle_inputs();

        // Reset state
        #2;
        chk("reset busy",      busy,            32'h0);
        chk("reset err",       32'(err),        32'h0);
        chk("reset iss_ready", 32'(iss_ready),  32'h1);
        chk("reset ld_ready",  32'(ld_ready),   32'h1);
        chk("reset fpu_ready", 32'(fpu_ready),  32'h1);
        chk("reset rbusy",     32'(rbusy),      32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table: issue/writeback, zero reg, collision, bypass, WAW
        for (int i = 0; i < 21; i++) begin
            iss_valid = tbl[i].iss_v; iss_waddr = tbl[i].iss_a;
            fpu_valid = tbl[i].fpu_v; fpu_waddr = tbl[i].fpu_a; fpu_wdata = tbl[i].fpu_d;
            ld_valid  = tbl[i].ld_v;  ld_waddr  = tbl[i].ld_a;  ld_wdata  = tbl[i].ld_d;
            raddr     = {tbl[i].ra, tbl[i].ra, tbl[i].ra};
            cycle_mid();
            chk($sformatf("tbl%0d ld_ready", i),  32'(ld_ready),  32'(tbl[i].e_ldr));
            chk($sformatf("tbl%0d fpu_ready", i), 32'(fpu_ready), 32'(tbl[i].e_fpr));
            chk($sformatf("tbl%0d iss_ready", i), 32'(iss_ready), 32'(tbl[i].e_issr));
            chk($sformatf("tbl%0d rdata_a", i),   rdata[0],       tbl[i].e_rd);
            chk($sformatf("tbl%0d rbusy_a", i),   32'(rbusy[0]),  32'(tbl[i].e_rb));
            chk($sformatf("tbl%0d busy", i),      busy,           tbl[i].e_busy);
            chk($sformatf("tbl%0d err", i),       32'(err),       32'(tbl[i].e_err));
            cycle_end();
        end

        // Reset mid-operation: f4 busy, colliding writes to f4 in flight
        iss_valid = 1'b0; iss_waddr = 5'd4;
        fpu_valid = 1'b1; fpu_waddr = 5'd4; fpu_wdata = 32'h55555555;
        ld_valid  = 1'b1; ld_waddr  = 5'd4; ld_wdata  = 32'h66666666;
        raddr     = {5'd4, 5'd4, 5'd4};
        #1;
        rst = 1'b1;
        #1;
        chk("rst busy immediate",  busy,           32'h0);
        chk("rst err immediate",   32'(err),       32'h0);
        chk("rst iss_ready",       32'(iss_ready), 32'h1);
        chk("rst ld_ready",        32'(ld_ready),  32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post-rst ld_ready (LD_PRI)",  32'(ld_ready),  32'h1);
        chk("post-rst fpu_ready (LD_PRI)", 32'(fpu_ready), 32'h0);
        fpu_valid = 1'b0;
        ld_valid  = 1'b0;
        #1;
        chk("post-rst f4 retained", rdata[0],        32'h44444444);
        chk("post-rst rbusy f4",    32'(rbusy[0]),   32'h0);
        chk("post-rst busy",        busy,            32'h0);
        model_reset();
        @(posedge clk);
        #1;

        // Write without issue to f9 (with same-cycle issue of f9: set wins), err sticky
        idle_inputs();
        iss_valid = 1'b1; iss_waddr = 5'd9;
        ld_valid  = 1'b1; ld_waddr  = 5'd9; ld_wdata = 32'h99999999;
        raddr     = {5'd9, 5'd9, 5'd9};
        cycle_mid();
        chk("wren err before", 32'(err), 32'h0);
        cycle_end();
        idle_inputs();
        raddr = {5'd9, 5'd9, 5'd9};
        cycle_mid();
        chk("wren err next cycle", 32'(err), 32'h1);
        chk("set wins busy f9",    busy,     32'h200);
        chk("f9 data",             rdata[0], 32'h99999999);
        cycle_end();
        for (int k = 0; k < 3; k++) begin
            cycle_mid();
            chk($sformatf("wren err held %0d", k), 32'(err), 32'h1);
            cycle_end();
        end
        rst = 1'b1;
        #1;
        chk("err cleared by rst", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Randomized traffic on a small address window to force collisions
        for (int n = 0; n < 600; n++) begin
            iss_valid = 1'($urandom_range(0, 1));
            iss_waddr = 5'($urandom_range(0, 7));
            fpu_valid = ($urandom_range(0, 99) < 45);
            fpu_waddr = 5'($urandom_range(0, 7));
            fpu_wdata = $urandom;
            ld_valid  = ($urandom_range(0, 99) < 45);
            ld_waddr  = 5'($urandom_range(0, 7));
            ld_wdata  = $urandom;
            for (int p = 0; p < 3; p++) raddr[p] = 5'($urandom_range(0, 8));
            cycle_mid();
            cycle_end();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
